// File: rtl/pcs_pkg.sv
// Shared constants for the 64b/66b PCS scrambler / descrambler.
// Polynomial 1 + x^39 + x^58, with the 58-bit history reset to all ones by default.
package pcs_pkg;

  localparam int SCR_TAP_A   = 39;
  localparam int SCR_TAP_B   = 58;
  localparam int SCR_STATE_W = 58;

  localparam logic [SCR_STATE_W-1:0] SCR_SEED_DEFAULT = 58'h3FF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/scr_xor_net.sv
// One-beat self-synchronous scrambler / descrambler network.
// state[0] is the most recent x bit; bit 0 of in_data is the first on the line.
module scr_xor_net
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DESCRAMBLE = 0
) (
  input  logic [SCR_STATE_W-1:0] state,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [SCR_STATE_W-1:0] next_state
);

  localparam int XW = SCR_STATE_W + DATA_WIDTH;

  // x history oldest-first: entries below SCR_STATE_W come from the stored
  // state, the rest are this beat's x bits, so bit n can reach bit n-39.
  logic [XW-1:0]         xs;
  logic [DATA_WIDTH-1:0] res;

  always_comb begin
    xs  = '0;
    res = '0;
    for (int m = 0; m < SCR_STATE_W; m++) begin
      xs[m] = state[SCR_STATE_W-1-m];
    end
    for (int j = 0; j < DATA_WIDTH; j++) begin
      res[j] = in_data[j]
             ^ xs[j + SCR_STATE_W - SCR_TAP_A]
             ^ xs[j + SCR_STATE_W - SCR_TAP_B];
      xs[SCR_STATE_W + j] = (DESCRAMBLE != 0) ? in_data[j] : res[j];
    end
  end

  always_comb begin
    out_data   = res;
    next_state = '0;
    for (int i = 0; i < SCR_STATE_W; i++) begin
      next_state[i] = xs[XW-1-i];
    end
  end

endmodule

// File: rtl/pcs_scram_descram.sv
// 64b/66b payload scrambler or descrambler with a main + skid output buffer.
// Valid/ready: a beat moves when valid and ready are both high on a rising edge.
module pcs_scram_descram
  import pcs_pkg::*;
#(
  parameter int                     DATA_WIDTH = 64,
  parameter int                     DESCRAMBLE = 0,
  parameter logic [SCR_STATE_W-1:0] SEED       = SCR_SEED_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_header,
  input  logic                  in_data_valid,
  output logic                  in_data_ready,
  input  logic                  bypass,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_header,
  output logic                  out_data_valid,
  input  logic                  out_data_ready
);

  logic [SCR_STATE_W-1:0] state, state_n, net_state;
  logic [DATA_WIDTH-1:0]  net_data, beat_data;

  logic                  main_valid, main_valid_n;
  logic [DATA_WIDTH-1:0] main_data, main_data_n;
  logic [1:0]            main_header, main_header_n;
  logic                  skid_valid, skid_valid_n;
  logic [DATA_WIDTH-1:0] skid_data, skid_data_n;
  logic [1:0]            skid_header, skid_header_n;
  logic                  rdy;

  logic accept, xfer;

  scr_xor_net #(
    .DATA_WIDTH (DATA_WIDTH),
    .DESCRAMBLE (DESCRAMBLE)
  ) u_net (
    .state      (state),
    .in_data    (in_data),
    .out_data   (net_data),
    .next_state (net_state)
  );

  assign accept    = in_data_valid & rdy;
  assign xfer      = main_valid & out_data_ready;
  assign beat_data = bypass ? in_data : net_data;

  assign in_data_ready  = rdy;
  assign out_data_valid = main_valid;
  assign out_data       = main_data;
  assign out_header     = main_header;

  always_comb begin
    main_valid_n  = main_valid;
    main_data_n   = main_data;
    main_header_n = main_header;
    skid_valid_n  = skid_valid;
    skid_data_n   = skid_data;
    skid_header_n = skid_header;
    state_n       = (accept && !bypass) ? net_state : state;

    // Skid full implies ready low, so no accept can coincide with a skid drain.
    if (xfer) begin
      if (skid_valid) begin
        main_data_n   = skid_data;
        main_header_n = skid_header;
        skid_valid_n  = 1'b0;
      end else if (accept) begin
        main_data_n   = beat_data;
        main_header_n = in_header;
      end else begin
        main_valid_n  = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_valid_n  = 1'b1;
        main_data_n   = beat_data;
        main_header_n = in_header;
      end else begin
        skid_valid_n  = 1'b1;
        skid_data_n   = beat_data;
        skid_header_n = in_header;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEED;
      main_valid  <= 1'b0;
      main_data   <= '0;
      main_header <= 2'b00;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_header <= 2'b00;
      rdy         <= 1'b0;
    end else begin
      state       <= state_n;
      main_valid  <= main_valid_n;
      main_data   <= main_data_n;
      main_header <= main_header_n;
      skid_valid  <= skid_valid_n;
      skid_data   <= skid_data_n;
      skid_header <= skid_header_n;
      rdy         <= !skid_valid_n;
    end
  end

endmodule

// File: tb/tb_pcs_scram_descram.sv
// Bench for pcs_scram_descram: bit-serial reference scrambler, scoreboard,
// SEED=0 zero run, scrambler-to-descrambler chain and flow-control corners.
module tb_pcs_scram_descram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;

  // main scrambler under test
  logic [63:0] s_in_data;
  logic [1:0]  s_in_header;
  logic        s_in_valid, s_in_ready, s_bypass;
  logic [63:0] s_out_data;
  logic [1:0]  s_out_header;
  logic        s_out_valid, s_oready;
  logic        man_ready, rnd_ready, rand_en;
  assign s_oready = rand_en ? rnd_ready : man_ready;
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  // scrambler -> descrambler chain
  logic [63:0] c_in_data;
  logic [1:0]  c_in_header;
  logic        c_in_valid, c_in_ready;
  logic [63:0] l_data;
  logic [1:0]  l_header;
  logic        l_valid, l_ready;
  logic [63:0] d_out_data;
  logic [1:0]  d_out_header;
  logic        d_out_valid;
  logic        zero_bit = 1'b0;
  logic        one_bit  = 1'b1;

  // SEED = 0 scrambler fed all-zero beats
  logic [63:0] z_in_data = 64'd0;
  logic [1:0]  z_in_header = 2'b01;
  logic        z_in_valid, z_in_ready;
  logic [63:0] z_out_data;
  logic [1:0]  z_out_header;
  logic        z_out_valid;

  pcs_scram_descram #(.DATA_WIDTH(64), .DESCRAMBLE(0)) u_s (
    .clk(clk), .rst(rst),
    .in_data(s_in_data), .in_header(s_in_header), .in_data_valid(s_in_valid),
    .in_data_ready(s_in_ready), .bypass(s_bypass),
    .out_data(s_out_data), .out_header(s_out_header), .out_data_valid(s_out_valid),
    .out_data_ready(s_oready));

  pcs_scram_descram #(.DATA_WIDTH(64), .DESCRAMBLE(0)) u_c (
    .clk(clk), .rst(rst),
    .in_data(c_in_data), .in_header(c_in_header), .in_data_valid(c_in_valid),
    .in_data_ready(c_in_ready), .bypass(zero_bit),
    .out_data(l_data), .out_header(l_header), .out_data_valid(l_valid),
    .out_data_ready(l_ready));

  pcs_scram_descram #(.DATA_WIDTH(64), .DESCRAMBLE(1)) u_d (
    .clk(clk), .rst(rst),
    .in_data(l_data), .in_header(l_header), .in_data_valid(l_valid),
    .in_data_ready(l_ready), .bypass(zero_bit),
    .out_data(d_out_data), .out_header(d_out_header), .out_data_valid(d_out_valid),
    .out_data_ready(one_bit));

  pcs_scram_descram #(.DATA_WIDTH(64), .DESCRAMBLE(0), .SEED(58'd0)) u_z (
    .clk(clk), .rst(rst),
    .in_data(z_in_data), .in_header(z_in_header), .in_data_valid(z_in_valid),
    .in_data_ready(z_in_ready), .bypass(zero_bit),
    .out_data(z_out_data), .out_header(z_out_header), .out_data_valid(z_out_valid),
    .out_data_ready(one_bit));

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: x history as a bit queue, newest at the back, starting all ones.
  bit hist[$];

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b1);
  endtask

  task automatic model_beat(input logic [63:0] d, input logic byp, output logic [63:0] o);
    bit x39, x58, ob;
    o = d;
    if (!byp) begin
      for (int n = 0; n < 64; n++) begin
        x39 = hist[hist.size() - 39];
        x58 = hist[hist.size() - 58];
        ob  = d[n] ^ x39 ^ x58;
        o[n] = ob;
        hist.push_back(ob);
        void'(hist.pop_front());
      end
    end
  endtask

  // scoreboard for u_s
  logic [65:0] exp_q[$];
  int acc_cnt = 0, xfer_cnt = 0;
  int acc_cyc[$], out_cyc[$];

  always @(negedge clk) begin
    logic [63:0] m;
    if (rst) begin
      exp_q.delete();
      model_reset();
    end else begin
      if (s_out_valid && s_oready) begin
        xfer_cnt++;
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%h required=none", s_out_data);
        end else begin
          check("sb_beat", {s_out_header, s_out_data}, exp_q.pop_front());
        end
      end
      if (s_in_valid && s_in_ready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
        model_beat(s_in_data, s_bypass, m);
        exp_q.push_back({s_in_header, m});
      end
    end
  end

  logic [65:0] chain_q[$];
  int z_seen = 0;
  always @(negedge clk) begin
    if (!rst && d_out_valid) chain_q.push_back({d_out_header, d_out_data});
    if (!rst && z_out_valid) begin
      z_seen++;
      check("seed0_zero", {z_out_header, z_out_data}, {2'b01, 64'd0});
    end
  end

  // Offer one beat on u_s; returns at posedge+1 after the accepting edge.
  task automatic drive(input logic [63:0] d, input logic [1:0] h, input logic b);
    int t;
    t = 0;
    s_in_data = d; s_in_header = h; s_bypass = b; s_in_valid = 1'b1;
    @(negedge clk);
    while (!s_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL drive_timeout actual=no_accept required=accept");
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_in_data = {$urandom, $urandom};
    s_in_header = 2'($urandom);
    s_bypass = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || s_out_valid) && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_int("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic [63:0] exp_data;
    logic [1:0]  exp_hdr;
  } chain_vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        byp;
  } byp_vec_t;

  chain_vec_t ctbl[3];
  byp_vec_t   btbl[3];
  logic [65:0] held;
  logic        have_held;
  logic        stall_done;
  int          a0, x0, t;

  initial begin
    ctbl[0] = '{64'h78D5_5555_5555_5555, 2'b10, 64'h78D5_5555_5555_5555, 2'b10};
    ctbl[1] = '{64'hBBAA_5544_3322_1100, 2'b10, 64'hBBAA_5544_3322_1100, 2'b10};
    ctbl[2] = '{64'hCC71_3B28_B207_0707, 2'b10, 64'hCC71_3B28_B207_0707, 2'b10};
    btbl[0] = '{64'h0123_4567_89AB_CDEF, 2'b01, 1'b0};
    btbl[1] = '{64'hDEAD_BEEF_CAFE_F00D, 2'b10, 1'b1};
    btbl[2] = '{64'hFEDC_BA98_7654_3210, 2'b01, 1'b0};

    rst = 1'b1;
    s_in_data = 64'd0; s_in_header = 2'b00; s_in_valid = 1'b0; s_bypass = 1'b0;
    man_ready = 1'b1; rand_en = 1'b0;
    c_in_data = 64'd0; c_in_header = 2'b00; c_in_valid = 1'b0;
    z_in_valid = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 66'(s_out_valid), 66'd0);
    check("rst_out_data", 66'(s_out_data), 66'd0);
    check("rst_out_header", 66'(s_out_header), 66'd0);
    check("rst_in_ready", 66'(s_in_ready), 66'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rst", 66'(s_in_ready), 66'd1);

    // SEED = 0 with all-zero payload
    @(posedge clk); #1;
    z_in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    z_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (z_seen < 8) begin
      errors++;
      $display("FAIL seed0_count actual=%0d required>=8", z_seen);
    end

    // scrambler -> descrambler chain
    for (int i = 0; i < 3; i++) begin
      t = 0;
      c_in_data = ctbl[i].data; c_in_header = ctbl[i].hdr; c_in_valid = 1'b1;
      @(negedge clk);
      while (!c_in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk); #1;
      c_in_valid = 1'b0;
    end
    t = 0;
    while (chain_q.size() < 3 && t < 30) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_int("chain_count", chain_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (chain_q.size() > 0)
        check("chain_word", chain_q.pop_front(), {ctbl[i].exp_hdr, ctbl[i].exp_data});
    end

    // bypass on the middle beat
    for (int i = 0; i < 3; i++) drive(btbl[i].data, btbl[i].hdr, btbl[i].byp);
    drain();

    // output stalled for 4 cycles while 4 beats are offered
    man_ready = 1'b0;
    a0 = acc_cnt; x0 = xfer_cnt;
    have_held = 1'b0; stall_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) drive({$urandom, $urandom}, 2'($urandom_range(1, 2)), 1'b0);
        stall_done = 1'b1;
      end
    join_none
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s_out_valid) begin
        if (!have_held) begin
          held = {s_out_header, s_out_data};
          have_held = 1'b1;
        end else begin
          check("stall_hold", {s_out_header, s_out_data}, held);
        end
      end
    end
    check_int("stall_accepts", acc_cnt - a0, 2);
    check("stall_ready_low", 66'(s_in_ready), 66'd0);
    check("stall_valid", 66'(s_out_valid), 66'd1);
    @(posedge clk); #1;
    man_ready = 1'b1;
    t = 0;
    while (!stall_done && t < 50) begin
      @(posedge clk);
      t++;
    end
    drain();
    check_int("stall_xfers", xfer_cnt - x0, 4);

    // 16 back-to-back beats
    acc_cyc.delete(); out_cyc.delete();
    for (int k = 0; k < 16; k++) drive({$urandom, $urandom}, 2'($urandom_range(1, 2)), 1'b0);
    drain();
    check_int("burst_outs", out_cyc.size(), 16);
    if (out_cyc.size() == 16 && acc_cyc.size() == 16) begin
      for (int k = 0; k < 16; k++) check_int("burst_cycle", out_cyc[k], acc_cyc[0] + 1 + k);
    end

    // reset with two beats buffered
    man_ready = 1'b0;
    drive(64'h1111_2222_3333_4444, 2'b01, 1'b0);
    drive(64'h5555_6666_7777_8888, 2'b10, 1'b0);
    x0 = xfer_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 66'(s_out_valid), 66'd0);
    check("midrst_data", 66'(s_out_data), 66'd0);
    check("midrst_ready", 66'(s_in_ready), 66'd0);
    check_int("midrst_no_xfer", xfer_cnt - x0, 0);
    @(posedge clk); #1;
    man_ready = 1'b1;
    drive(64'h0F0F_0F0F_A5A5_5A5A, 2'b01, 1'b0);
    drain();

    // randomized traffic with random backpressure and bypass
    rand_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      drive({$urandom, $urandom}, 2'($urandom_range(1, 2)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    rand_en = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcs_scram_descram.md
PCS_SCRAM_DESCRAM -- requirements
Module: pcs_scram_descram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64; beat width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DESCRAMBLE, default 0; 0 selects scramble, 1 selects descramble.
REQ-003 The block SHALL have parameter SEED, default 58'h3FF_FFFF_FFFF_FFFF; the LFSR state value after reset.
REQ-004 The block SHALL have ports:
  clk  in  1  sole clock; all logic on rising edge.
  rst  in  1  reset; synchronous, active-high.
  in_data  in  DATA_WIDTH  input payload; bit 0 is first on the line.
  in_header  in  2  66b sync header; carried alongside, never scrambled.
  in_data_valid  in  1  input beat present.
  in_data_ready  out  1  block accepts the beat this cycle.
  bypass  in  1  sampled per accepted beat; 1 = pass data unmodified.
  out_data  out  DATA_WIDTH  processed payload.
  out_header  out  2  header of the same beat.
  out_data_valid  out  1  output beat present.
  out_data_ready  in  1  downstream accepts the beat.

Function
REQ-005 Polynomial SHALL be 1 + x^39 + x^58, self-synchronous: out bit n = in bit n XOR x(n-39) XOR x(n-58).
REQ-006 x SHALL be the output sequence when DESCRAMBLE=0 and the input sequence when DESCRAMBLE=1.
REQ-007 The 58-bit state SHALL hold the last 58 x bits, and all DATA_WIDTH bits SHALL be processed in one cycle, including intra-beat dependencies (bit n may depend on bit n-39 of the same beat).
REQ-008 Accept SHALL occur when in_data_valid and in_data_ready are both 1; output transfer SHALL occur when out_data_valid and out_data_ready are both 1.
REQ-009 The state SHALL advance only on an accepted beat with bypass=0; on an accepted beat with bypass=1, data SHALL pass unmodified and the state SHALL hold.
REQ-010 The datapath SHALL have a 2-entry output buffer (main + skid); latency SHALL be 1 cycle from accept to out_data_valid when the buffer is empty.
REQ-011 in_data_ready SHALL be registered and SHALL be 1 iff the skid entry is empty; it SHALL not depend combinationally on out_data_ready.
REQ-012 Simultaneous accept and output transfer with one entry occupied SHALL keep occupancy at 1 with no bubble, sustaining 1 beat/cycle.
REQ-013 With both entries full, in_data_ready SHALL be 0 and out_data/out_header SHALL be held stable until transfer.
REQ-014 Beat order SHALL be preserved, and the header SHALL travel with its own beat.
REQ-015 in_data/in_header SHALL be ignored when in_data_valid=0, and bypass SHALL be ignored when no beat is accepted.

Reset
REQ-016 While rst=1, the block SHALL set state=SEED, empty both entries, out_data_valid=0, out_data=0, out_header=2'b00, and in_data_ready=0.
REQ-017 in_data_ready SHALL rise on the first cycle after rst deasserts.
REQ-018 Reset mid-stream SHALL discard buffered beats with no output transfer, and the state SHALL restart from SEED.

Structure
REQ-019 Package pcs_pkg SHALL hold the constants SCR_TAP_A=39, SCR_TAP_B=58, SCR_STATE_W=58, and SCR_SEED_DEFAULT.
REQ-020 One combinational sub-module, scr_xor_net, SHALL compute out_data and next state from (state, in_data, DESCRAMBLE), parameterised by DATA_WIDTH.
REQ-021 A correct implementation SHALL be between 120 and 400 lines of RTL.

Verification
REQ-022 A bench SHALL cover SEED=0, DESCRAMBLE=0, with all-zero beats: out_data SHALL be 0 on every beat.
REQ-023 A bench SHALL cover a scrambler feeding a descrambler (both SEED default) driven with 64'h78D5_5555_5555_5555, 64'hBBAA_5544_3322_1100, and 64'hCC71_3B28_B207_0707 with headers 2'b10: the same words and headers SHALL emerge in order, the first word being bit-exact only after descrambler state convergence (from the 2nd beat onward for mismatched seeds).
REQ-024 A bench SHALL cover bypass=1 on beat 2 of 3: beat 2 output SHALL equal its input, and beat 3 output SHALL equal the no-bypass reference run of beats 1 and 3.
REQ-025 A bench SHALL cover out_data_ready=0 for 4 cycles while 4 beats are offered: exactly 2 beats SHALL be accepted, in_data_ready SHALL go 0, and the output SHALL be stable; on release, all 4 beats SHALL emerge in order with no loss.
REQ-026 A bench SHALL cover continuous valid/ready=1 for 16 beats: 16 outputs SHALL occur on 16 consecutive cycles, starting 1 cycle after the first accept.
REQ-027 A bench SHALL cover rst asserted for 1 cycle with 2 beats buffered: out_data_valid SHALL be 0 the next cycle, and the following beat SHALL be scrambled from SEED.
